// File: rtl/acc_datapath_gen.sv
// Accumulator-machine datapath: PC, IR, multi-word address assembly, AC,
// general register file, ALU and Z/N/C flags, sequenced by an external control unit.
module acc_datapath_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 4,
  localparam int RSEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              pc_load_sel,
  input  logic              addr_sel,
  input  logic              ir_en,
  input  logic              opcode_bypass,
  input  logic              addr_shift_en,
  input  logic              addr_clear,
  input  logic              ac_en,
  input  logic [1:0]        ac_src,
  input  logic              reg_en,
  input  logic [RSEL_W-1:0] rsel,
  input  logic              flag_en,
  input  logic              mem_we_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] opcode,
  output logic              addr_ready,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic [DATA_W-1:0] ac_out
);

  localparam int NBYTES = ADDR_W / DATA_W;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBYTES);

  logic [ADDR_W-1:0] pc_r, addr_r, addr_base_s, addr_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_base_s, cnt_next_s;
  logic              ready_r;
  logic [DATA_W-1:0] ir_r, ac_r, reg_b_s, alu_y_s, ac_next_s;
  logic [DATA_W-1:0] regs_r [NREGS];
  logic [DATA_W:0]   add_s, sub_s, inc_s;
  logic              alu_c_s, z_r, n_r, c_r, ac_load_s, flag_load_s;
  logic [2:0]        op_s;

  assign opcode    = opcode_bypass ? mem_rdata : ir_r;
  assign op_s      = opcode[2:0];
  assign reg_b_s   = regs_r[rsel];
  assign mem_addr  = addr_sel ? addr_r : pc_r;
  assign mem_wdata = ac_r;
  assign mem_we    = mem_we_in;
  assign ac_out    = ac_r;
  assign flag_z    = z_r;
  assign flag_n    = n_r;
  assign flag_c    = c_r;
  assign addr_ready = ready_r;

  // Address assembly next-state; a clear is applied before a same-cycle shift
  always_comb begin
    addr_base_s = addr_r;
    cnt_base_s  = cnt_r;
    if (addr_clear) begin
      addr_base_s = '0;
      cnt_base_s  = '0;
    end else begin
      addr_base_s = addr_r;
      cnt_base_s  = cnt_r;
    end
    addr_next_s = addr_base_s;
    cnt_next_s  = cnt_base_s;
    if (addr_shift_en) begin
      addr_next_s = (addr_base_s << DATA_W) | ADDR_W'(mem_rdata);
      if (cnt_base_s != CNT_MAX) begin
        cnt_next_s = cnt_base_s + CNT_W'(1);
      end else begin
        cnt_next_s = cnt_base_s;
      end
    end else begin
      addr_next_s = addr_base_s;
      cnt_next_s  = cnt_base_s;
    end
  end

  // Address register, word counter and ready flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= '0;
      cnt_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      addr_r  <= addr_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (cnt_next_s == CNT_MAX);
    end
  end

  // Program counter and instruction register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= '0;
      ir_r <= '0;
    end else begin
      if (pc_en) begin
        pc_r <= pc_load_sel ? addr_r : pc_r + ADDR_W'(1);
      end
      if (ir_en) begin
        ir_r <= mem_rdata;
      end
    end
  end

  assign add_s = {1'b0, ac_r} + {1'b0, reg_b_s};
  assign sub_s = {1'b0, ac_r} + {1'b0, ~reg_b_s} + (DATA_W+1)'(1);
  assign inc_s = {1'b0, ac_r} + (DATA_W+1)'(1);

  // ALU result and carry selection
  always_comb begin
    alu_y_s = '0;
    alu_c_s = 1'b0;
    case (op_s)
      3'b000:  begin alu_y_s = add_s[DATA_W-1:0]; alu_c_s = add_s[DATA_W]; end
      3'b001:  begin alu_y_s = sub_s[DATA_W-1:0]; alu_c_s = sub_s[DATA_W]; end
      3'b010:  alu_y_s = ac_r & reg_b_s;
      3'b011:  alu_y_s = ac_r | reg_b_s;
      3'b100:  alu_y_s = ac_r ^ reg_b_s;
      3'b101:  alu_y_s = ~ac_r;
      3'b110:  begin alu_y_s = inc_s[DATA_W-1:0]; alu_c_s = inc_s[DATA_W]; end
      3'b111:  alu_y_s = '0;
      default: alu_y_s = '0;
    endcase
  end

  // AC source select; source 11 means hold, which also freezes the flags
  always_comb begin
    ac_next_s = ac_r;
    case (ac_src)
      2'b00:   ac_next_s = alu_y_s;
      2'b01:   ac_next_s = mem_rdata;
      2'b10:   ac_next_s = reg_b_s;
      2'b11:   ac_next_s = ac_r;
      default: ac_next_s = ac_r;
    endcase
  end

  assign ac_load_s   = ac_en   && (ac_src != 2'b11);
  assign flag_load_s = flag_en && (ac_src != 2'b11);

  // Accumulator and flags; flags follow ac_next even when AC is not loaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ac_r <= '0;
      z_r  <= 1'b1;
      n_r  <= 1'b0;
      c_r  <= 1'b0;
    end else begin
      if (ac_load_s) begin
        ac_r <= ac_next_s;
      end
      if (flag_load_s) begin
        z_r <= (ac_next_s == '0);
        n_r <= ac_next_s[DATA_W-1];
        c_r <= (ac_src == 2'b00) ? alu_c_s : 1'b0;
      end
    end
  end

  // Register file written with the pre-edge AC, so AC<->reg swaps work
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (reg_en) begin
      regs_r[rsel] <= ac_r;
    end
  end

endmodule

// File: tb/tb_acc_datapath_gen.sv
// Self-checking bench for acc_datapath_gen: vector table with a scoreboard queue
// plus directed sequences for reset, PC wrap, memory write and opcode bypass.
module tb_acc_datapath_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       pc_en, pc_load_sel, addr_sel, ir_en, opcode_bypass;
  logic       addr_shift_en, addr_clear, ac_en, reg_en, flag_en, mem_we_in;
  logic [1:0] ac_src, rsel;
  logic [7:0] mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata, opcode, ac_out;
  logic       mem_we, addr_ready, flag_z, flag_n, flag_c;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  ac;
    logic        z, n, c;
    logic [15:0] addr;
    logic        rdy;
  } exp_t;

  typedef struct packed {
    logic       pc_en, pc_ls, asel, ir_en, byp, shf, clr, ac_en;
    logic [1:0] src;
    logic       reg_en;
    logic [1:0] rsel;
    logic       flag_en;
    logic [7:0] rdata;
    exp_t       e;
  } vec_t;

  vec_t tbl [31];
  exp_t sb_q [$];

  acc_datapath_gen #(.DATA_W(8), .ADDR_W(16), .NREGS(4)) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_load_sel(pc_load_sel),
    .addr_sel(addr_sel), .ir_en(ir_en), .opcode_bypass(opcode_bypass),
    .addr_shift_en(addr_shift_en), .addr_clear(addr_clear), .ac_en(ac_en),
    .ac_src(ac_src), .reg_en(reg_en), .rsel(rsel), .flag_en(flag_en),
    .mem_we_in(mem_we_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .opcode(opcode),
    .addr_ready(addr_ready), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .ac_out(ac_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    input logic pe, input logic pls, input logic as, input logic ie,
    input logic by, input logic sh, input logic cl, input logic ae,
    input logic [1:0] sr, input logic re, input logic [1:0] rs,
    input logic fe, input logic [7:0] rd, input logic [7:0] eac,
    input logic ez, input logic en, input logic ec,
    input logic [15:0] ead, input logic erd);
    vec_t v;
    v.pc_en = pe; v.pc_ls = pls; v.asel = as; v.ir_en = ie; v.byp = by;
    v.shf = sh; v.clr = cl; v.ac_en = ae; v.src = sr; v.reg_en = re;
    v.rsel = rs; v.flag_en = fe; v.rdata = rd;
    v.e.ac = eac; v.e.z = ez; v.e.n = en; v.e.c = ec;
    v.e.addr = ead; v.e.rdy = erd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic idle();
    pc_en = 1'b0; pc_load_sel = 1'b0; addr_sel = 1'b0; ir_en = 1'b0;
    opcode_bypass = 1'b0; addr_shift_en = 1'b0; addr_clear = 1'b0;
    ac_en = 1'b0; ac_src = 2'b00; reg_en = 1'b0; rsel = 2'b00;
    flag_en = 1'b0; mem_we_in = 1'b0; mem_rdata = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    pc_en = v.pc_en; pc_load_sel = v.pc_ls; addr_sel = v.asel; ir_en = v.ir_en;
    opcode_bypass = v.byp; addr_shift_en = v.shf; addr_clear = v.clr;
    ac_en = v.ac_en; ac_src = v.src; reg_en = v.reg_en; rsel = v.rsel;
    flag_en = v.flag_en; mem_we_in = 1'b0; mem_rdata = v.rdata;
  endtask

  initial begin
    exp_t e;
    //            pe pls as ie by sh cl ae src    re rs     fe rdata   ac     z    n    c    addr      rdy
    tbl[0]  = mk(1,0,0,0,0,0,0,0,2'b00,0,2'd0,0,8'h00, 8'h00,1,0,0,16'h0001,0);
    tbl[1]  = mk(1,0,0,0,0,0,0,0,2'b00,0,2'd0,0,8'h00, 8'h00,1,0,0,16'h0002,0);
    tbl[2]  = mk(1,0,0,0,0,0,0,0,2'b00,0,2'd0,0,8'h00, 8'h00,1,0,0,16'h0003,0);
    tbl[3]  = mk(0,0,0,0,0,0,1,0,2'b00,0,2'd0,0,8'h00, 8'h00,1,0,0,16'h0003,0);
    tbl[4]  = mk(0,0,1,0,0,1,0,0,2'b00,0,2'd0,0,8'h12, 8'h00,1,0,0,16'h0012,0);
    tbl[5]  = mk(0,0,1,0,0,1,0,0,2'b00,0,2'd0,0,8'h34, 8'h00,1,0,0,16'h1234,1);
    tbl[6]  = mk(1,1,0,0,0,0,0,0,2'b00,0,2'd0,0,8'h00, 8'h00,1,0,0,16'h1234,1);
    tbl[7]  = mk(0,0,1,0,0,1,0,0,2'b00,0,2'd0,0,8'h56, 8'h00,1,0,0,16'h3456,1);
    tbl[8]  = mk(0,0,1,0,0,1,1,0,2'b00,0,2'd0,0,8'hAB, 8'h00,1,0,0,16'h00AB,0);
    tbl[9]  = mk(0,0,0,0,0,0,0,0,2'b00,0,2'd0,0,8'h00, 8'h00,1,0,0,16'h1234,0);
    tbl[10] = mk(0,0,0,0,0,0,0,1,2'b01,0,2'd0,0,8'h01, 8'h01,1,0,0,16'h1234,0);
    tbl[11] = mk(0,0,0,0,0,0,0,0,2'b00,1,2'd2,0,8'h00, 8'h01,1,0,0,16'h1234,0);
    tbl[12] = mk(0,0,0,0,0,0,0,1,2'b01,0,2'd0,1,8'hFF, 8'hFF,0,1,0,16'h1234,0);
    tbl[13] = mk(0,0,0,0,1,0,0,1,2'b00,0,2'd2,1,8'h00, 8'h00,1,0,1,16'h1234,0);
    tbl[14] = mk(0,0,0,0,0,0,0,1,2'b01,0,2'd0,0,8'h02, 8'h02,1,0,1,16'h1234,0);
    tbl[15] = mk(0,0,0,0,0,0,0,0,2'b00,1,2'd2,0,8'h00, 8'h02,1,0,1,16'h1234,0);
    tbl[16] = mk(0,0,0,0,0,0,0,1,2'b01,0,2'd0,0,8'h01, 8'h01,1,0,1,16'h1234,0);
    tbl[17] = mk(0,0,0,0,1,0,0,1,2'b00,0,2'd2,1,8'h01, 8'hFF,0,1,0,16'h1234,0);
    tbl[18] = mk(0,0,0,0,1,0,0,1,2'b00,0,2'd2,1,8'hF8, 8'h01,0,0,1,16'h1234,0);
    tbl[19] = mk(0,0,0,0,1,0,0,1,2'b00,0,2'd2,1,8'h04, 8'h03,0,0,0,16'h1234,0);
    tbl[20] = mk(0,0,0,0,1,0,0,1,2'b00,0,2'd2,1,8'h05, 8'hFC,0,1,0,16'h1234,0);
    tbl[21] = mk(0,0,0,0,1,0,0,1,2'b00,0,2'd2,1,8'h06, 8'hFD,0,1,0,16'h1234,0);
    tbl[22] = mk(0,0,0,0,1,0,0,0,2'b00,0,2'd2,1,8'h07, 8'hFD,1,0,0,16'h1234,0);
    tbl[23] = mk(0,0,0,0,0,0,0,1,2'b11,0,2'd2,1,8'h00, 8'hFD,1,0,0,16'h1234,0);
    tbl[24] = mk(0,0,0,0,1,0,0,1,2'b00,0,2'd2,1,8'h02, 8'h00,1,0,0,16'h1234,0);
    tbl[25] = mk(0,0,0,0,1,0,0,1,2'b00,0,2'd2,1,8'h03, 8'h02,0,0,0,16'h1234,0);
    tbl[26] = mk(0,0,0,0,0,0,0,1,2'b01,0,2'd0,0,8'hC3, 8'hC3,0,0,0,16'h1234,0);
    tbl[27] = mk(0,0,0,0,0,0,0,0,2'b00,1,2'd3,0,8'h00, 8'hC3,0,0,0,16'h1234,0);
    tbl[28] = mk(0,0,0,0,0,0,0,1,2'b01,0,2'd0,0,8'h5A, 8'h5A,0,0,0,16'h1234,0);
    tbl[29] = mk(0,0,0,0,0,0,0,1,2'b10,1,2'd3,0,8'h00, 8'hC3,0,0,0,16'h1234,0);
    tbl[30] = mk(0,0,0,0,0,0,0,1,2'b10,0,2'd3,0,8'h00, 8'h5A,0,0,0,16'h1234,0);

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_ac", ac_out, 8'h00);
    check("rst_flags", {flag_z, flag_n, flag_c}, 3'b100);
    check("rst_ready", addr_ready, 1'b0);
    check("rst_opcode", opcode, 8'h00);
    reset = 1'b1;

    for (int i = 0; i < 31; i++) begin
      apply(tbl[i]);
      sb_q.push_back(tbl[i].e);
      tick();
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("v%0d_ac", i), ac_out, e.ac);
        check($sformatf("v%0d_flags", i), {flag_z, flag_n, flag_c}, {e.z, e.n, e.c});
        check($sformatf("v%0d_mem_addr", i), mem_addr, e.addr);
        check($sformatf("v%0d_ready", i), addr_ready, e.rdy);
      end
    end
    check("sb_drained", sb_q.size(), 0);

    // PC wrap: assemble 0xFFFF, jump, then increment
    idle(); addr_clear = 1'b1; addr_shift_en = 1'b1; mem_rdata = 8'hFF; tick();
    idle(); addr_shift_en = 1'b1; mem_rdata = 8'hFF; tick();
    check("ffff_ready", addr_ready, 1'b1);
    idle(); pc_en = 1'b1; pc_load_sel = 1'b1; tick();
    check("pc_ffff", mem_addr, 16'hFFFF);
    idle(); pc_en = 1'b1; tick();
    check("pc_wrap", mem_addr, 16'h0000);
    idle(); ac_en = 1'b1; ac_src = 2'b01; mem_rdata = 8'h77; tick();
    idle(); addr_sel = 1'b1; mem_we_in = 1'b1; #1;
    check("wr_addr", mem_addr, 16'hFFFF);
    check("wr_wdata", mem_wdata, 8'h77);
    check("wr_we", mem_we, 1'b1);

    // Opcode bypass then IR capture
    idle(); opcode_bypass = 1'b1; mem_rdata = 8'h9C; #1;
    check("op_bypass", opcode, 8'h9C);
    ir_en = 1'b1; tick();
    idle(); #1;
    check("op_ir", opcode, 8'h9C);

    // Asynchronous reset between clock edges
    reset = 1'b0; #1;
    check("async_ac", ac_out, 8'h00);
    check("async_mem_addr", mem_addr, 16'h0000);
    check("async_flags", {flag_z, flag_n, flag_c}, 3'b100);
    check("async_ready", addr_ready, 1'b0);
    check("async_opcode", opcode, 8'h00);
    tick();
    reset = 1'b1;
    pc_en = 1'b1;
    repeat (3) tick();
    idle(); #1;
    check("refetch_mem_addr", mem_addr, 16'h0003);
    check("refetch_z", flag_z, 1'b1);
    check("refetch_ac", ac_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
